// File: rtl/nioshello_ram_loader_pkg.sv
// Shared types and constants for the niosHello RAM loader.
package nioshello_ram_loader_pkg;

    localparam int DEFAULT_ADDR_W = 16;
    localparam int DEFAULT_CNT_W  = DEFAULT_ADDR_W + 1;
    localparam int LANES          = 4;
    localparam int BYTE_W         = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FILL    = 2'd1,
        FLUSH   = 2'd2,
        DONE_ST = 2'd3
    } state_t;

    // Byteenable with the lowest n lanes set (n = 0..LANES).
    function automatic logic [LANES-1:0] be_from_count(input logic [2:0] n);
        logic [4:0] mask;
        mask = (5'd1 << n) - 5'd1;
        return mask[LANES-1:0];
    endfunction

endpackage

// File: rtl/nioshello_ram_loader_if.sv
// Byte stream in and RAM write port out; master is the loader side, slave is
// the environment (stream source plus RAM).
interface nioshello_ram_loader_if
    import nioshello_ram_loader_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W
) ();

    logic [BYTE_W-1:0]       in_data;
    logic                    in_valid;
    logic                    in_eop;
    logic                    in_ready;
    logic [ADDR_W-1:0]       ram_address;
    logic [LANES-1:0]        ram_byteenable;
    logic [LANES*BYTE_W-1:0] ram_writedata;
    logic                    ram_write;
    logic                    ram_chipselect;
    logic                    ram_clken;

    modport master (
        input  in_data, in_valid, in_eop,
        output in_ready,
        output ram_address, ram_byteenable, ram_writedata,
        output ram_write, ram_chipselect, ram_clken
    );

    modport slave (
        output in_data, in_valid, in_eop,
        input  in_ready,
        input  ram_address, ram_byteenable, ram_writedata,
        input  ram_write, ram_chipselect, ram_clken
    );

endinterface

// File: rtl/nioshello_ram_loader_packer.sv
// Little-endian byte-to-word packer; presents a finished word combinationally
// in the cycle its completing byte is accepted.
module nioshello_ram_loader_packer
    import nioshello_ram_loader_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    accept,
    input  logic [BYTE_W-1:0]       byte_in,
    input  logic                    eop,
    output logic                    word_valid,
    output logic [LANES*BYTE_W-1:0] word,
    output logic [LANES-1:0]        be
);

    logic [1:0]              lane_q;
    logic [LANES*BYTE_W-1:0] pack_q;
    logic [LANES-1:0]        be_q;

    // Merge the incoming byte so the word can be handed off with no bubble.
    always_comb begin
        word_valid = accept && ((lane_q == 2'(LANES - 1)) || eop);
        word       = pack_q;
        word[lane_q*BYTE_W +: BYTE_W] = byte_in;
        be         = be_q | (LANES'(1) << lane_q);
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            lane_q <= '0;
            pack_q <= '0;
            be_q   <= '0;
        end else if (accept) begin
            if (word_valid) begin
                lane_q <= '0;
                pack_q <= '0;
                be_q   <= '0;
            end else begin
                lane_q <= lane_q + 2'd1;
                pack_q <= word;
                be_q   <= be;
            end
        end
    end

endmodule

// File: rtl/nioshello_ram_loader.sv
// Byte-stream to on-chip RAM loader: packs bytes into 32-bit words and writes
// them to consecutive word addresses starting at a programmed base.
//
// state   | meaning
// IDLE    | waiting for start
// FILL    | accepting stream bytes
// FLUSH   | final word is on the RAM port
// DONE_ST | one-cycle done pulse
module nioshello_ram_loader
    import nioshello_ram_loader_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int CNT_W  = DEFAULT_CNT_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [ADDR_W-1:0]      base_addr,
    input  logic [CNT_W-1:0]       max_words,
    nioshello_ram_loader_if.master bus,
    output logic                   busy,
    output logic                   done,
    output logic [CNT_W-1:0]       words_written
);

    state_t                  state_q;
    state_t                  state_d;
    logic                    in_ready_c;
    logic                    start_ok;
    logic                    accept;
    logic                    limit_hit;
    logic                    word_valid;
    logic [LANES*BYTE_W-1:0] word;
    logic [LANES-1:0]        word_be;

    logic [ADDR_W-1:0]       base_q;
    logic [CNT_W-1:0]        max_q;
    logic [CNT_W-1:0]        words_q;
    logic                    wr_q;
    logic [ADDR_W-1:0]       addr_q;
    logic [LANES*BYTE_W-1:0] data_q;
    logic [LANES-1:0]        be_q;

    assign start_ok  = start && (state_q == IDLE);
    assign accept    = bus.in_valid && in_ready_c;
    // Non-final words take four accepts, so words_q is current whenever a word completes.
    assign limit_hit = (words_q + CNT_W'(1)) == max_q;

    nioshello_ram_loader_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (start_ok),
        .accept     (accept),
        .byte_in    (bus.in_data),
        .eop        (bus.in_eop),
        .word_valid (word_valid),
        .word       (word),
        .be         (word_be)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (max_words == '0) ? DONE_ST : FILL;
                end
            end
            FILL: begin
                if (word_valid && (bus.in_eop || limit_hit)) begin
                    state_d = FLUSH;
                end
            end
            FLUSH:   state_d = DONE_ST;
            DONE_ST: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready_c = (state_q == FILL);
        busy       = (state_q != IDLE);
        done       = (state_q == DONE_ST);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            base_q  <= '0;
            max_q   <= '0;
            words_q <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            be_q    <= '0;
        end else begin
            wr_q <= word_valid;
            if (start_ok) begin
                base_q  <= base_addr;
                max_q   <= max_words;
                words_q <= '0;
            end else if (wr_q) begin
                words_q <= words_q + CNT_W'(1);
            end
            // Address arithmetic wraps at the RAM size by truncation.
            if (word_valid) begin
                addr_q <= base_q + words_q[ADDR_W-1:0];
                data_q <= word;
                be_q   <= word_be;
            end
        end
    end

    assign bus.in_ready       = in_ready_c;
    assign bus.ram_address    = addr_q;
    assign bus.ram_writedata  = data_q;
    assign bus.ram_byteenable = be_q;
    assign bus.ram_write      = wr_q;
    assign bus.ram_chipselect = wr_q;
    assign bus.ram_clken      = 1'b1;
    assign words_written      = words_q;

endmodule

// File: tb/tb_nioshello_ram_loader.sv
// Directed bench for the niosHello RAM loader with hand-computed expectations.
module tb_nioshello_ram_loader;

    localparam int ADDR_W = 16;
    localparam int CNT_W  = 17;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [CNT_W-1:0]  max_words;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  words_written;

    nioshello_ram_loader_if #(.ADDR_W(ADDR_W)) bus ();

    nioshello_ram_loader #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .base_addr     (base_addr),
        .max_words     (max_words),
        .bus           (bus),
        .busy          (busy),
        .done          (done),
        .words_written (words_written)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    logic [ADDR_W-1:0] wa[$];
    logic [31:0]       wd[$];
    logic [3:0]        wb[$];
    int                done_cnt = 0;
    int                acc_cnt  = 0;
    logic              cs_err   = 1'b0;

    always @(negedge clk) begin
        if (bus.ram_write === 1'b1) begin
            wa.push_back(bus.ram_address);
            wd.push_back(bus.ram_writedata);
            wb.push_back(bus.ram_byteenable);
        end
        if (done === 1'b1) done_cnt++;
        if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) acc_cnt++;
        if (bus.ram_chipselect !== bus.ram_write || bus.ram_clken !== 1'b1) cs_err = 1'b1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_log();
        wa.delete();
        wd.delete();
        wb.delete();
    endtask

    task automatic pulse_start(input logic [ADDR_W-1:0] base, input logic [CNT_W-1:0] max);
        start     = 1'b1;
        base_addr = base;
        max_words = max;
        cycles(1);
        start     = 1'b0;
        base_addr = 16'hDEAD;
        max_words = 17'h1_0000;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic eop, input int gap);
        logic got;
        got = 1'b0;
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        bus.in_eop   = eop;
        for (int i = 0; i < 16 && !got; i++) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) got = 1'b1;
            @(posedge clk);
            #1;
        end
        if (!got) check("accept_timeout", 64'd0, 64'd1);
        bus.in_valid = 1'b0;
        bus.in_eop   = 1'b0;
        cycles(gap);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                n = i;
                break;
            end
        end
        if (n == 0) check("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic chk_write(input int idx, input logic [ADDR_W-1:0] a,
                             input logic [31:0] d, input logic [3:0] b);
        if (idx < wa.size()) begin
            check($sformatf("wr%0d_addr", idx), 64'(wa[idx]), 64'(a));
            check($sformatf("wr%0d_data", idx), 64'(wd[idx]), 64'(d));
            check($sformatf("wr%0d_be", idx),   64'(wb[idx]), 64'(b));
        end else begin
            check($sformatf("wr%0d_missing", idx), 64'(wa.size()), 64'(idx + 1));
        end
    endtask

    int n;
    int d0;

    initial begin
        reset        = 1'b1;
        start        = 1'b0;
        base_addr    = '0;
        max_words    = '0;
        bus.in_data  = '0;
        bus.in_valid = 1'b0;
        bus.in_eop   = 1'b0;
        cycles(3);
        reset = 1'b0;

        // Reset values
        @(negedge clk);
        check("rst_ctrl", 64'({bus.in_ready, bus.ram_write, bus.ram_chipselect, busy, done}), 64'd0);
        check("rst_addr", 64'(bus.ram_address), 64'd0);
        check("rst_data", 64'({bus.ram_writedata, bus.ram_byteenable}), 64'd0);
        check("rst_words", 64'(words_written), 64'd0);
        check("rst_clken", 64'(bus.ram_clken), 64'd1);
        cycles(1);

        // Two full words, eop on the last byte
        clear_log();
        d0 = done_cnt;
        pulse_start(16'h0100, 17'd16);
        for (int i = 1; i <= 8; i++) send_byte(8'(8'h11 * i), i == 8, 0);
        @(negedge clk);
        check("t1_ready_after_eop", 64'(bus.in_ready), 64'd0);
        check("t1_flush_write", 64'(bus.ram_write), 64'd1);
        wait_done(n);
        check("t1_done_latency", 64'(n), 64'd1);
        @(negedge clk);
        check("t1_busy_fall", 64'(busy), 64'd0);
        cycles(2);
        check("t1_nwrites", 64'(wa.size()), 64'd2);
        chk_write(0, 16'h0100, 32'h4433_2211, 4'b1111);
        chk_write(1, 16'h0101, 32'h8877_6655, 4'b1111);
        check("t1_words", 64'(words_written), 64'd2);
        check("t1_done_cnt", 64'(done_cnt - d0), 64'd1);

        // Partial final word
        clear_log();
        pulse_start(16'h0200, 17'd16);
        send_byte(8'hAA, 1'b0, 0);
        send_byte(8'hBB, 1'b0, 0);
        send_byte(8'hCC, 1'b1, 0);
        wait_done(n);
        check("t2_done_latency", 64'(n), 64'd2);
        cycles(2);
        check("t2_nwrites", 64'(wa.size()), 64'd1);
        chk_write(0, 16'h0200, 32'h00CC_BBAA, 4'b0111);
        check("t2_words", 64'(words_written), 64'd1);

        // Word limit with an over-long stream
        clear_log();
        d0 = done_cnt;
        pulse_start(16'h0600, 17'd2);
        acc_cnt = 0;
        for (int i = 0; i < 8; i++) send_byte(8'(8'h30 + i), 1'b0, 0);
        bus.in_data  = 8'h99;
        bus.in_valid = 1'b1;
        @(negedge clk);
        check("t3_ready_after_limit", 64'(bus.in_ready), 64'd0);
        cycles(6);
        bus.in_valid = 1'b0;
        check("t3_accepted", 64'(acc_cnt), 64'd8);
        check("t3_nwrites", 64'(wa.size()), 64'd2);
        chk_write(0, 16'h0600, 32'h3332_3130, 4'b1111);
        chk_write(1, 16'h0601, 32'h3736_3534, 4'b1111);
        check("t3_done_cnt", 64'(done_cnt - d0), 64'd1);
        check("t3_words", 64'(words_written), 64'd2);

        // Address wrap with a gappy stream
        clear_log();
        d0 = done_cnt;
        pulse_start(16'hFFFF, 17'd3);
        for (int i = 1; i <= 12; i++) send_byte(8'(i), 1'b0, 1);
        cycles(4);
        check("t4_nwrites", 64'(wa.size()), 64'd3);
        chk_write(0, 16'hFFFF, 32'h0403_0201, 4'b1111);
        chk_write(1, 16'h0000, 32'h0807_0605, 4'b1111);
        chk_write(2, 16'h0001, 32'h0C0B_0A09, 4'b1111);
        check("t4_done_cnt", 64'(done_cnt - d0), 64'd1);
        check("t4_busy", 64'(busy), 64'd0);

        // Reset six bytes into a load
        clear_log();
        d0 = done_cnt;
        pulse_start(16'h0300, 17'd16);
        for (int i = 0; i < 6; i++) send_byte(8'(8'h21 + i), 1'b0, 0);
        reset = 1'b1;
        cycles(1);
        reset = 1'b0;
        @(negedge clk);
        check("t5_rst_ctrl", 64'({bus.in_ready, bus.ram_write, busy, done}), 64'd0);
        check("t5_rst_addr", 64'(bus.ram_address), 64'd0);
        check("t5_rst_data", 64'({bus.ram_writedata, bus.ram_byteenable}), 64'd0);
        check("t5_rst_words", 64'(words_written), 64'd0);
        cycles(4);
        check("t5_nwrites", 64'(wa.size()), 64'd1);
        chk_write(0, 16'h0300, 32'h2423_2221, 4'b1111);
        check("t5_no_done", 64'(done_cnt - d0), 64'd0);

        // Start while busy must not retarget the load
        clear_log();
        pulse_start(16'h0400, 17'd2);
        send_byte(8'h41, 1'b0, 0);
        send_byte(8'h42, 1'b0, 0);
        pulse_start(16'h0500, 17'd1);
        for (int i = 0; i < 6; i++) send_byte(8'(8'h43 + i), 1'b0, 0);
        cycles(4);
        check("t6_nwrites", 64'(wa.size()), 64'd2);
        chk_write(0, 16'h0400, 32'h4443_4241, 4'b1111);
        chk_write(1, 16'h0401, 32'h4847_4645, 4'b1111);
        check("t6_words", 64'(words_written), 64'd2);

        // Zero-length load
        clear_log();
        pulse_start(16'h0700, 17'd0);
        wait_done(n);
        check("t7_done_latency", 64'(n), 64'd1);
        cycles(4);
        check("t7_nwrites", 64'(wa.size()), 64'd0);
        check("t7_words", 64'(words_written), 64'd0);

        check("cs_clken", 64'(cs_err), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/nioshello_ram_loader.md
Name: niosHello_ram_loader

Overview:
- Upstream feeder for the niosHello on-chip RAM's second Avalon-MM slave port.
- Accepts a byte stream (e.g. from a UART or JTAG receiver) over a valid/ready handshake and packs bytes little-endian into 32-bit words.
- Writes each word into the RAM at consecutive word addresses from a programmed base; partial final words use byteenable.
- Host-side control is a start pulse plus busy/done/count status.

Parameters:
- ADDR_W, 16, RAM word-address width; must match the RAM's widthad.
- CNT_W, 17, width of max_words and words_written; equals ADDR_W+1 so a full 65536-word load is expressible.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a load; ignored while busy=1.
- base_addr  in  ADDR_W  first RAM word address, sampled on an accepted start.
- max_words  in  CNT_W  word limit, sampled on an accepted start.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data is valid.
- in_eop  in  1  current byte is the last byte of the load.
- in_ready  out  1  loader accepts in_data this cycle.
- ram_address  out  ADDR_W  RAM word address.
- ram_byteenable  out  4  byte lanes being written.
- ram_writedata  out  32  write word.
- ram_write  out  1  write strobe.
- ram_chipselect  out  1  always equal to ram_write.
- ram_clken  out  1  constant 1.
- busy  out  1  a load is in progress.
- done  out  1  one-cycle completion pulse.
- words_written  out  CNT_W  words written in the current or most recent load.

Behaviour:
- Reset values: in_ready=0, ram_write=0, ram_chipselect=0, ram_byteenable=0, ram_writedata=0, ram_address=0, busy=0, done=0, words_written=0.
- During reset: ram_clken=1, state=IDLE, lane index=0, pack register cleared.
- Reset mid-load: reset takes effect on the next clock edge; any write not yet issued is dropped; no done pulse.
- States:
  - IDLE: waiting for start.
  - FILL: accepting bytes.
  - FLUSH: final write cycle.
  - DONE_ST: one cycle, done=1.
- Transitions:
  - IDLE->FILL on start, with max_words != 0.
  - IDLE->DONE_ST on start with max_words == 0; no writes occur.
  - FILL->FLUSH when the completing byte is accepted and either in_eop=1 or that word is number max_words.
  - FLUSH->DONE_ST unconditionally.
  - DONE_ST->IDLE unconditionally.
- Control signals:
  - busy=1 in FILL, FLUSH and DONE_ST.
  - in_ready=1 only in FILL; it is a function of registered state only, with no combinational path from in_valid.
  - A byte is accepted when in_valid & in_ready.
- Packing:
  - The byte accepted at lane index k (0..3) lands in writedata[8k+7:8k]; lane index increments on each accept.
  - A word is complete on acceptance at lane 3, or on acceptance with in_eop=1.
  - Unfilled lanes are 0 in writedata, with byteenable bits clear; byteenable has bit k set for each filled lane (eop after 1/2/3/4 bytes gives 0001/0011/0111/1111).
- Write timing:
  - If a word completes in cycle C, the write is issued in cycle C+1: ram_write=1, address=(base_addr+n) mod 2^ADDR_W, where n = words already written.
  - The RAM has no waitrequest, so every write is single-cycle.
  - The pack register is separate from the write register, so FILL sustains 1 byte/cycle with no bubble.
  - words_written increments at the edge ending each write cycle.
- Completion:
  - If the completing byte is the last one, in_ready=0 from C+1 (FLUSH, carrying the write).
  - done=1 at C+2 (DONE_ST); busy falls at C+3.
- Boundary rules:
  - in_eop outside FILL is ignored.
  - Once the max_words limit is reached, extra stream bytes are not consumed.
  - The address wraps silently from 2^ADDR_W-1 to 0.
  - start is ignored while busy.

Decomposition:
- Package niosHello_ram_loader_pkg holds:
  - ADDR_W and CNT_W defaults;
  - state enum {IDLE, FILL, FLUSH, DONE_ST};
  - LANES=4 and BYTE_W=8;
  - function be_from_count(n) returning the byteenable for n filled lanes.
- One sub-module, niosHello_ram_loader_packer, holds the lane index, the pack register and the byteenable accumulator. It outputs word_valid/word/be for a single cycle on completion.
- The top level holds the FSM, address/count logic and the RAM write register.

Test Plan:
- Load, no limit hit:
  - Stimulus: start base=0x0100, max=16; 8 bytes 11..88 back-to-back, eop on 88.
  - Response: writes 0x44332211 @0x0100 be=1111, then 0x88776655 @0x0101 be=1111; done 2 cycles after the last byte accepted; words_written=2.
- Partial final word:
  - Stimulus: start base=0x0200; 3 bytes AA BB CC, eop on CC.
  - Response: one write 0x00CCBBAA @0x0200 be=0111; done; words_written=1.
- Word limit:
  - Stimulus: start max=2; 12 bytes offered continuously, no eop.
  - Response: exactly 8 accepted; in_ready=0 from the cycle after byte 8; 2 writes; done; bytes 9-12 left unconsumed.
- Address wrap and stream gaps:
  - Stimulus: start base=0xFFFF, max=3; 12 bytes with in_valid toggling 1/0.
  - Response: writes at 0xFFFF, 0x0000, 0x0001; data correct despite gaps.
- Reset mid-load and start while busy:
  - Stimulus: 6 bytes into a load, assert reset for 1 cycle.
  - Response: all outputs at reset values the next cycle; no done pulse; only the first word was written.
  - Follow-up: a start pulse issued during a later FILL is ignored (base unchanged).
- Zero-length load:
  - Stimulus: start with max_words=0.
  - Response: no ram_write; done=1 one cycle after start; words_written=0.
